extend_seq: RTL and testbench

- Parametrised, handshaked successor to the single-cycle immediate extender in the ARM-style datapath.
- Takes the instruction immediate field plus an immediate-source select and produces the 32-bit extended immediate.
- Adds the rotated-imm8 encoding, computed by an iterative rotator, and the split halfword immediate.
- Sits between decode and execute; uses a valid/ready handshake on both sides so multi-cycle rotates can stall decode.

---
 rtl/extend_pkg.sv | 32 +++
 rtl/extend_seq_ror2_step.sv | 24 ++
 rtl/extend_seq.sv | 182 ++++++++++++++++++
 tb/tb_extend_seq.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/extend_pkg.sv
// Shared types and constants for the handshaked immediate extender.
// Contents: imm_src_t (immediate-source codes), state_t (FSM states),
// ROT_FIELD_W (width of the rotate field) and rot_step(), which gives the
// number of 2-bit rotate steps to take in one cycle.
package extend_pkg;

   localparam int unsigned ROT_FIELD_W = 4;
   localparam int unsigned IMM_SRC_W   = 3;
   localparam int unsigned STEP_W      = 5;   // holds 0..16

   typedef enum logic [IMM_SRC_W-1:0] {
      IMM8   = 3'b000,
      IMM12  = 3'b001,
      BRANCH = 3'b010,
      ROTIMM = 3'b011,
      HALF   = 3'b100
   } imm_src_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ROT  = 2'd1,
      HOLD = 2'd2
   } state_t;

   // Steps to take this cycle: min(remaining, per_cyc)
   function automatic logic [STEP_W-1:0] rot_step(input logic [ROT_FIELD_W-1:0] rem,
                                                  input int unsigned per_cyc);
      if (32'(rem) < per_cyc) return STEP_W'(rem);
      else                    return STEP_W'(per_cyc);
   endfunction

endpackage

// File: rtl/extend_seq_ror2_step.sv
// ror2_step: combinational rotate-right of a DATA_W word by 2*k bits.
// Bits leaving bit 0 re-enter at bit DATA_W-1.
// Ports:
//   word_i  in  DATA_W  word to rotate
//   k_i     in  K_W     number of 2-bit steps (0..ROT_PER_CYC)
//   word_o  out DATA_W  rotated word
module ror2_step #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned K_W    = 5
) (
   input  logic [DATA_W-1:0] word_i,
   input  logic [K_W-1:0]    k_i,
   output logic [DATA_W-1:0] word_o
);

   int unsigned sh;

   // A left shift by DATA_W yields zero, so k=0 passes the word through.
   always_comb begin
      sh     = 2 * 32'(k_i);
      word_o = (word_i >> sh) | (word_i << (DATA_W - sh));
   end

endmodule

// File: rtl/extend_seq.sv
// extend_seq: handshaked immediate extender sitting between decode and
// execute. Produces a DATA_W-bit extended immediate from an instruction
// field; rotated-imm8 immediates are rotated iteratively, ROT_PER_CYC
// 2-bit steps per cycle, which stalls decode through in_ready.
// Optional feature macro: EXTEND_ILLEGAL_ERR_EN (adds the err output).
// Ports:
//   clk        in   1        clock, rising edge
//   reset      in   1        asynchronous active-high reset
//   in_valid   in   1        request valid
//   in_ready   out  1        block can accept a request
//   instr      in   INSTR_W  instruction bits
//   imm_src    in   3        immediate-source select
//   carry_in   in   1        current C flag
//   out_valid  out  1        result valid
//   out_ready  in   1        consumer accepts result
//   ext_imm    out  DATA_W   extended immediate
//   carry_out  out  1        shifter carry-out
//   err        out  1        illegal imm_src (only with EXTEND_ILLEGAL_ERR_EN)
// Parameter legality: DATA_W >= 26, INSTR_W <= DATA_W - BR_SHIFT,
// ROT_PER_CYC in {1, 2, 4, 8, 16}.
module extend_seq
   import extend_pkg::*;
#(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned INSTR_W     = 24,
   parameter int unsigned BR_SHIFT    = 2,
   parameter int unsigned ROT_PER_CYC = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [INSTR_W-1:0] instr,
   input  logic [2:0]         imm_src,
   input  logic               carry_in,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [DATA_W-1:0]  ext_imm,
`ifdef EXTEND_ILLEGAL_ERR_EN
   output logic               err,
`endif
   output logic               carry_out
);

   state_t                 state_q, state_d;
   logic [DATA_W-1:0]      work_q, work_d;
   logic [ROT_FIELD_W-1:0] rem_q, rem_d;
   logic                   carry_q, carry_d;
   logic                   in_ready_q, in_ready_d;
   logic                   out_valid_q, out_valid_d;
`ifdef EXTEND_ILLEGAL_ERR_EN
   logic                   err_q, err_d;
`endif

   logic [DATA_W-1:0]      imm_val_c;
   logic                   illegal_c;
   logic [ROT_FIELD_W-1:0] rot_fld_c;
   logic [STEP_W-1:0]      step_c;
   logic [DATA_W-1:0]      rot_word_c;
   logic [DATA_W-1:0]      sext_c;

   assign rot_fld_c = instr[11:8];
   assign sext_c    = {{(DATA_W-INSTR_W){instr[INSTR_W-1]}}, instr};
   assign step_c    = rot_step(rem_q, ROT_PER_CYC);

   // Non-iterative immediate decode; ROTIMM yields the unrotated imm8
   always_comb begin
      imm_val_c = '0;
      illegal_c = 1'b0;
      case (imm_src_t'(imm_src))
         IMM8:    imm_val_c = DATA_W'(instr[7:0]);
         IMM12:   imm_val_c = DATA_W'(instr[11:0]);
         BRANCH:  imm_val_c = sext_c << BR_SHIFT;
         ROTIMM:  imm_val_c = DATA_W'(instr[7:0]);
         HALF:    imm_val_c = DATA_W'({instr[11:8], instr[3:0]});
         default: illegal_c = 1'b1;
      endcase
   end

   ror2_step #(
      .DATA_W (DATA_W),
      .K_W    (STEP_W)
   ) u_ror2_step (
      .word_i (work_q),
      .k_i    (step_c),
      .word_o (rot_word_c)
   );

   // Next-state and output logic
   always_comb begin
      state_d     = state_q;
      work_d      = work_q;
      rem_d       = rem_q;
      carry_d     = carry_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
`ifdef EXTEND_ILLEGAL_ERR_EN
      err_d       = err_q;
`endif
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               carry_d    = carry_in;
               in_ready_d = 1'b0;
               work_d     = imm_val_c;
               if ((imm_src_t'(imm_src) == ROTIMM) && (rot_fld_c != '0)) begin
                  rem_d   = rot_fld_c;
                  state_d = ROT;
               end else begin
                  state_d     = HOLD;
                  out_valid_d = 1'b1;
`ifdef EXTEND_ILLEGAL_ERR_EN
                  err_d       = illegal_c;
`endif
               end
            end
         end
         ROT: begin
            work_d = rot_word_c;
            rem_d  = rem_q - ROT_FIELD_W'(step_c);
            if (rem_d == '0) begin
               state_d     = HOLD;
               out_valid_d = 1'b1;
               carry_d     = rot_word_c[DATA_W-1];
            end
         end
         HOLD: begin
            // Result and carry stay frozen until the consumer takes them
            if (out_ready) begin
               state_d     = IDLE;
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
`ifdef EXTEND_ILLEGAL_ERR_EN
               err_d       = 1'b0;
`endif
            end
         end
         default: begin
            state_d     = IDLE;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
         end
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         work_q      <= '0;
         rem_q       <= '0;
         carry_q     <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
`ifdef EXTEND_ILLEGAL_ERR_EN
         err_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         work_q      <= work_d;
         rem_q       <= rem_d;
         carry_q     <= carry_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
`ifdef EXTEND_ILLEGAL_ERR_EN
         err_q       <= err_d;
`endif
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign ext_imm   = work_q;
   assign carry_out = carry_q;
`ifdef EXTEND_ILLEGAL_ERR_EN
   assign err       = err_q;
`else
   logic unused_illegal;
   assign unused_illegal = illegal_c;
`endif

endmodule

// File: tb/tb_extend_seq.sv
// Testbench for extend_seq: directed vector table, reset-abort sequence,
// then randomized requests checked against a behavioural model.
module tb_extend_seq;

   localparam int unsigned DATA_W  = 32;
   localparam int unsigned INSTR_W = 24;
   localparam int unsigned BR_SH   = 2;
   localparam int unsigned RPC     = 1;

   logic               clk;
   logic               reset;
   logic               in_valid;
   logic               in_ready;
   logic [INSTR_W-1:0] instr;
   logic [2:0]         imm_src;
   logic               carry_in;
   logic               out_valid;
   logic               out_ready;
   logic [DATA_W-1:0]  ext_imm;
   logic               carry_out;
`ifdef EXTEND_ILLEGAL_ERR_EN
   logic               err;
`endif

   int n_cmp  = 0;
   int n_fail = 0;

   extend_seq #(
      .DATA_W      (DATA_W),
      .INSTR_W     (INSTR_W),
      .BR_SHIFT    (BR_SH),
      .ROT_PER_CYC (RPC)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .instr     (instr),
      .imm_src   (imm_src),
      .carry_in  (carry_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .ext_imm   (ext_imm),
`ifdef EXTEND_ILLEGAL_ERR_EN
      .err       (err),
`endif
      .carry_out (carry_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Behavioural reference: arithmetic from the immediate-source rules
   function automatic void model(input logic [INSTR_W-1:0] ins, input logic [2:0] src,
                                 input logic cin, output logic [DATA_W-1:0] e,
                                 output logic c, output int lat);
      int          r;
      int signed   off;
      logic [DATA_W-1:0] x;
      e   = '0;
      c   = cin;
      lat = 1;
      case (src)
         3'd0: e = DATA_W'(ins[7:0]);
         3'd1: e = DATA_W'(ins[11:0]);
         3'd2: begin
            off = int'($signed(ins));
            e   = DATA_W'(off * (1 << BR_SH));
         end
         3'd3: begin
            x = DATA_W'(ins[7:0]);
            r = 2 * int'(ins[11:8]);
            for (int i = 0; i < int'(DATA_W); i++) e[i] = x[(i + r) % int'(DATA_W)];
            if (ins[11:8] != 4'd0) begin
               c   = e[DATA_W-1];
               lat = 1 + (int'(ins[11:8]) + int'(RPC) - 1) / int'(RPC);
            end
         end
         3'd4: e = DATA_W'(ins[11:8] * 16 + ins[3:0]);
         default: e = '0;
      endcase
   endfunction

   // One full request: accept, wait for result, optional backpressure, release
   task automatic run_txn(input logic [INSTR_W-1:0] ins, input logic [2:0] src,
                          input logic cin, input logic [DATA_W-1:0] e_ext,
                          input logic e_c, input int e_lat, input int stall);
      int lat;
      logic [DATA_W-1:0] held;
      @(negedge clk);
      chk("in_ready_before_accept", 32'(in_ready), 32'd1);
      in_valid  = 1'b1;
      instr     = ins;
      imm_src   = src;
      carry_in  = cin;
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      in_valid = 1'b0;
      instr    = INSTR_W'($urandom);
      imm_src  = 3'($urandom);
      carry_in = 1'($urandom_range(0, 1));
      lat = 1;
      while (!out_valid && lat < 64) begin
         out_ready = 1'($urandom_range(0, 1));
         in_valid  = 1'($urandom_range(0, 1));
         @(negedge clk);
         lat++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      chk("latency", 32'(lat), 32'(e_lat));
      chk("ext_imm", 32'(ext_imm), 32'(e_ext));
      chk("carry_out", 32'(carry_out), 32'(e_c));
`ifdef EXTEND_ILLEGAL_ERR_EN
      chk("err", 32'(err), 32'(src >= 3'd5));
`endif
      held = ext_imm;
      for (int s = 0; s < stall; s++) begin
         in_valid = 1'b1;
         instr    = INSTR_W'($urandom);
         imm_src  = 3'($urandom);
         @(negedge clk);
         chk("stall_ext_stable", 32'(ext_imm), 32'(held));
         chk("stall_carry", 32'(carry_out), 32'(e_c));
         chk("stall_in_ready", 32'(in_ready), 32'd0);
         chk("stall_out_valid", 32'(out_valid), 32'd1);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("release_out_valid", 32'(out_valid), 32'd0);
      chk("release_in_ready", 32'(in_ready), 32'd1);
   endtask

   typedef struct {
      logic [INSTR_W-1:0] ins;
      logic [2:0]         src;
      logic               cin;
      logic [DATA_W-1:0]  ext;
      logic               cry;
      int                 lat;
      int                 stall;
   } vec_t;

   vec_t tbl[11];

   initial begin
      logic [DATA_W-1:0] e;
      logic              c;
      int                l;

      tbl[0]  = '{24'h0000A5, 3'd0, 1'b1, 32'h000000A5, 1'b1, 1,  0};
      tbl[1]  = '{24'hFFFFFE, 3'd2, 1'b0, 32'hFFFFFFF8, 1'b0, 1,  0};
      tbl[2]  = '{24'h000004, 3'd2, 1'b1, 32'h00000010, 1'b1, 1,  0};
      tbl[3]  = '{24'h0004FF, 3'd3, 1'b0, 32'hFF000000, 1'b1, 5,  5};
      tbl[4]  = '{24'h000F01, 3'd3, 1'b0, 32'h00000004, 1'b0, 16, 0};
      tbl[5]  = '{24'h000001, 3'd3, 1'b1, 32'h00000001, 1'b1, 1,  0};
      tbl[6]  = '{24'h123ABC, 3'd1, 1'b0, 32'h00000ABC, 1'b0, 1,  2};
      tbl[7]  = '{24'h000A5B, 3'd4, 1'b1, 32'h000000AB, 1'b1, 1,  0};
      tbl[8]  = '{24'hFFFFFF, 3'd7, 1'b1, 32'h00000000, 1'b1, 1,  0};
      tbl[9]  = '{24'h800000, 3'd2, 1'b0, 32'hFE000000, 1'b0, 1,  0};
      tbl[10] = '{24'h000F80, 3'd3, 1'b1, 32'h00000200, 1'b0, 16, 1};

      reset     = 1'b1;
      in_valid  = 1'b0;
      instr     = '0;
      imm_src   = '0;
      carry_in  = 1'b0;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_in_ready", 32'(in_ready), 32'd1);
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_ext_imm", 32'(ext_imm), 32'd0);
      chk("reset_carry", 32'(carry_out), 32'd0);
`ifdef EXTEND_ILLEGAL_ERR_EN
      chk("reset_err", 32'(err), 32'd0);
`endif
      reset = 1'b0;

      for (int i = 0; i < 11; i++)
         run_txn(tbl[i].ins, tbl[i].src, tbl[i].cin, tbl[i].ext, tbl[i].cry,
                 tbl[i].lat, tbl[i].stall);

      // Reset asserted during the second ROT cycle aborts the rotate
      @(negedge clk);
      in_valid = 1'b1;
      instr    = 24'h0004FF;
      imm_src  = 3'd3;
      carry_in = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("abort_out_valid", 32'(out_valid), 32'd0);
      chk("abort_in_ready", 32'(in_ready), 32'd1);
      chk("abort_ext_imm", 32'(ext_imm), 32'd0);
      chk("abort_carry", 32'(carry_out), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (6) @(negedge clk);
      chk("abort_no_result", 32'(out_valid), 32'd0);

      // Randomized requests against the model
      for (int n = 0; n < 60; n++) begin
         logic [INSTR_W-1:0] ri;
         logic [2:0]         rs;
         logic               rc;
         ri = INSTR_W'($urandom);
         rs = 3'($urandom_range(0, 7));
         rc = 1'($urandom_range(0, 1));
         model(ri, rs, rc, e, c, l);
         run_txn(ri, rs, rc, e, c, l, int'($urandom_range(0, 3)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
